// File: rtl/move_scheduler_pkg.sv
// Shared definitions for the move scheduler: direction encoding,
// scheduler FSM states and small helpers.
package move_scheduler_pkg;

  // 2-bit move direction: 0 up, 1 down, 2 left, 3 right
  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    SCHED_WELCOME,
    SCHED_IDLE,
    SCHED_ISSUE,
    SCHED_WAIT_DONE,
    SCHED_WAIT_FRAME
  } sched_state_t;

  // True when exactly one of the four button bits is set
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO of 2-bit move directions with occupancy count.
// Push while full and pop while empty are ignored; simultaneous push and
// pop both take effect and leave the count unchanged.
module move_fifo
  import move_scheduler_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_push,
  input  dir_t          i_data,
  input  logic          i_pop,
  output dir_t          o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  dir_t          r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage write; entries need no reset since count gates visibility
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; clear empties the queue in one cycle
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok)  r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Move scheduler: turns debounced direction buttons into one-at-a-time
// move requests for the game logic, commits grids on frame boundaries and
// sequences the welcome screen.
// Optional auto-repeat of a held direction: define MOVE_SCHEDULER_REPEAT_EN.
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned DONE_TIMEOUT  = 255,
  parameter int unsigned REPEAT_FRAMES = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              frame_start,
  input  logic [3:0]                        btn,
  output logic                              move_valid,
  output logic [1:0]                        move_dir,
  input  logic                              move_ready,
  input  logic                              move_done,
  output logic                              grid_commit,
  output logic                              show_welcome,
  output logic                              game_start,
  output logic                              timeout,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   queue_count
);

  localparam int unsigned TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DONE_TIMEOUT - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      DONE_TIMEOUT < 1 || REPEAT_FRAMES < 2) begin : g_bad_params
    $error("move_scheduler: illegal parameter combination");
  end

  sched_state_t  r_state;
  logic [TW-1:0] r_timer;
  logic          r_game_start;
  logic          r_timeout;
  logic          r_grid_commit;
  logic [3:0]    r_btn_prev;
  logic [3:0]    r_pending;
  dir_t          r_ptr;

  logic [3:0]    w_press;
  logic [3:0]    w_inject;
  logic [3:0]    w_grant;
  dir_t          w_win;
  logic          w_win_vld;
  logic          w_push;
  logic          w_pop;
  logic          w_clr;
  dir_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] w_count;

  assign w_press = btn & ~r_btn_prev;

  // Round-robin pick: first pending direction at or after the pointer
  always_comb begin
    dir_t v_idx;
    v_idx     = DIR_UP;
    w_win     = DIR_UP;
    w_win_vld = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      v_idx = r_ptr + k[1:0];
      if (!w_win_vld && r_pending[v_idx]) begin
        w_win     = v_idx;
        w_win_vld = 1'b1;
      end
    end
    w_grant = w_win_vld ? (4'b0001 << w_win) : 4'b0000;
  end

  assign w_push = w_win_vld && !w_full && (r_state != SCHED_WELCOME);
  assign w_pop  = (r_state == SCHED_ISSUE) && move_ready;
  assign w_clr  = (r_state == SCHED_WELCOME) && (w_press != 4'b0000);

  move_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_data  (w_win),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef MOVE_SCHEDULER_REPEAT_EN
  localparam int unsigned RCW = $clog2(REPEAT_FRAMES + REPEAT_FRAMES / 2 + 1);
  localparam logic [RCW-1:0] RPT_FIRST = RCW'(REPEAT_FRAMES);
  localparam logic [RCW-1:0] RPT_NEXT  = RCW'(REPEAT_FRAMES + REPEAT_FRAMES / 2);

  logic [RCW-1:0] r_rep_cnt;
  logic [3:0]     r_rep_pat;
  logic [RCW-1:0] w_rep_cnt_nxt;
  logic           w_rep_hold;

  assign w_rep_cnt_nxt = r_rep_cnt + 1'b1;
  assign w_rep_hold    = is_onehot4(btn) && (btn == r_rep_pat) &&
                         (r_state != SCHED_WELCOME);
  assign w_inject      = (w_rep_hold && frame_start &&
                          (w_rep_cnt_nxt == RPT_FIRST || w_rep_cnt_nxt == RPT_NEXT))
                         ? btn : 4'b0000;

  // Frame counter for a single held direction; after the first repeat the
  // count folds back to REPEAT_FRAMES so later repeats land every half period
  always_ff @(posedge clk) begin
    if (reset || r_state == SCHED_WELCOME || !is_onehot4(btn)) begin
      r_rep_cnt <= '0;
      r_rep_pat <= 4'b0000;
    end else if (btn != r_rep_pat) begin
      r_rep_cnt <= '0;
      r_rep_pat <= btn;
    end else if (frame_start) begin
      r_rep_cnt <= (w_rep_cnt_nxt == RPT_NEXT) ? RPT_FIRST : w_rep_cnt_nxt;
    end
  end
`else
  assign w_inject = 4'b0000;
`endif

  // Edge history, pending-press mask and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_prev <= 4'b1111;
      r_pending  <= 4'b0000;
      r_ptr      <= DIR_UP;
    end else begin
      r_btn_prev <= btn;
      if (r_state == SCHED_WELCOME) begin
        r_pending <= 4'b0000;
      end else begin
        r_pending <= (r_pending & ~(w_push ? w_grant : 4'b0000)) | w_press | w_inject;
        if (w_push) r_ptr <= w_win + 2'd1;
      end
    end
  end

  // Scheduler FSM with registered one-cycle pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= SCHED_WELCOME;
      r_timer       <= '0;
      r_game_start  <= 1'b0;
      r_timeout     <= 1'b0;
      r_grid_commit <= 1'b0;
    end else begin
      r_game_start  <= 1'b0;
      r_timeout     <= 1'b0;
      r_grid_commit <= 1'b0;
      case (r_state)
        SCHED_WELCOME: begin
          if (w_press != 4'b0000) begin
            r_game_start <= 1'b1;
            r_state      <= SCHED_IDLE;
          end
        end
        SCHED_IDLE: begin
          if (!w_empty && frame_start) r_state <= SCHED_ISSUE;
        end
        SCHED_ISSUE: begin
          if (move_ready) begin
            r_timer <= '0;
            r_state <= SCHED_WAIT_DONE;
          end
        end
        SCHED_WAIT_DONE: begin
          if (move_done) begin
            r_state <= SCHED_WAIT_FRAME;
          end else if (r_timer == TIMER_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= SCHED_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        SCHED_WAIT_FRAME: begin
          if (frame_start) begin
            r_grid_commit <= 1'b1;
            r_state       <= SCHED_IDLE;
          end
        end
        default: r_state <= SCHED_WELCOME;
      endcase
    end
  end

  assign show_welcome = (r_state == SCHED_WELCOME);
  assign move_valid   = (r_state == SCHED_ISSUE);
  assign move_dir     = (r_state == SCHED_ISSUE) ? w_head : DIR_UP;
  assign game_start   = r_game_start;
  assign timeout      = r_timeout;
  assign grid_commit  = r_grid_commit;
  assign queue_count  = w_count;

endmodule

// File: tb/tb_move_scheduler.sv
// Testbench for move_scheduler: directed scenarios with literal
// expectations plus randomized stimulus against a behavioural model.
module tb_move_scheduler;

  localparam int DEPTH = 4;
  localparam int DT    = 255;
  localparam int RF    = 12;

  localparam int ST_WELCOME = 0;
  localparam int ST_IDLE    = 1;
  localparam int ST_ISSUE   = 2;
  localparam int ST_WDONE   = 3;
  localparam int ST_WFRAME  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [3:0] btn = 4'b0001;
  logic       move_ready = 1'b0;
  logic       move_done = 1'b0;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       grid_commit;
  logic       show_welcome;
  logic       game_start;
  logic       timeout;
  logic [2:0] queue_count;

  int checks = 0;
  int failures = 0;
  bit en = 1'b0;

  always #5 clk = ~clk;

  move_scheduler #(
    .FIFO_DEPTH    (DEPTH),
    .DONE_TIMEOUT  (DT),
    .REPEAT_FRAMES (RF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .btn          (btn),
    .move_valid   (move_valid),
    .move_dir     (move_dir),
    .move_ready   (move_ready),
    .move_done    (move_done),
    .grid_commit  (grid_commit),
    .show_welcome (show_welcome),
    .game_start   (game_start),
    .timeout      (timeout),
    .queue_count  (queue_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending set, queue of directions, scheduler phase
  int       m_st = ST_WELCOME;
  int       m_q[$];
  bit [3:0] m_pend = 4'b0000;
  bit [3:0] m_prev = 4'b1111;
  int       m_ptr = 0;
  int       m_timer = 0;
  bit       m_gs = 1'b0, m_to = 1'b0, m_gc = 1'b0;
  int       m_rcnt = 0;
  bit [3:0] m_rpat = 4'b0000;

  always @(posedge clk) begin : model
    bit [3:0] press;
    bit [3:0] inj;
    int win;
    int d;
    press  = btn & ~m_prev;
    m_prev = btn;
    inj    = 4'b0000;
`ifdef MOVE_SCHEDULER_REPEAT_EN
    if (reset || m_st == ST_WELCOME || $countones(btn) != 1) begin
      m_rcnt = 0;
      m_rpat = 4'b0000;
    end else if (btn != m_rpat) begin
      m_rpat = btn;
      m_rcnt = 0;
    end else if (frame_start) begin
      m_rcnt++;
      if (m_rcnt == RF || m_rcnt == RF + RF / 2) inj = btn;
      if (m_rcnt == RF + RF / 2) m_rcnt = RF;
    end
`endif
    if (reset) begin
      m_st = ST_WELCOME; m_q.delete(); m_pend = 4'b0000; m_prev = 4'b1111;
      m_ptr = 0; m_timer = 0; m_gs = 0; m_to = 0; m_gc = 0;
    end else begin
      m_gs = 0; m_to = 0; m_gc = 0;
      if (m_st == ST_WELCOME) begin
        if (press != 4'b0000) begin
          m_gs = 1; m_st = ST_IDLE; m_q.delete(); m_pend = 4'b0000;
        end
      end else begin
        win = -1;
        if (m_q.size() < DEPTH)
          for (int k = 0; k < 4; k++) begin
            d = (m_ptr + k) % 4;
            if (win < 0 && m_pend[d]) win = d;
          end
        case (m_st)
          ST_IDLE:   if (m_q.size() > 0 && frame_start) m_st = ST_ISSUE;
          ST_ISSUE:  if (move_ready) begin
                       void'(m_q.pop_front()); m_timer = 0; m_st = ST_WDONE;
                     end
          ST_WDONE:  if (move_done) m_st = ST_WFRAME;
                     else if (m_timer == DT - 1) begin m_to = 1; m_st = ST_IDLE; end
                     else m_timer++;
          ST_WFRAME: if (frame_start) begin m_gc = 1; m_st = ST_IDLE; end
          default:   m_st = ST_WELCOME;
        endcase
        if (win >= 0) begin
          m_q.push_back(win); m_pend[win] = 1'b0; m_ptr = (win + 1) % 4;
        end
        m_pend = m_pend | press | inj;
      end
    end
  end

  // Compare every output against the model each cycle, away from the edge
  always @(negedge clk) begin
    if (en) begin
      chk("m_show_welcome", show_welcome, m_st == ST_WELCOME);
      chk("m_move_valid", move_valid, m_st == ST_ISSUE);
      chk("m_move_dir", move_dir, (m_st == ST_ISSUE) ? m_q[0] : 0);
      chk("m_queue_count", queue_count, m_q.size());
      chk("m_game_start", game_start, m_gs);
      chk("m_timeout", timeout, m_to);
      chk("m_grid_commit", grid_commit, m_gc);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue the queue head through to WAIT_FRAME, checking its direction
  task automatic do_move(input int exp_dir);
    frame_start = 1; step(); frame_start = 0;
    chk("dm_valid", move_valid, 1);
    chk("dm_dir", move_dir, exp_dir);
    move_ready = 1; step(); move_ready = 0;
    move_done = 1; step(); move_done = 0;
  endtask

  initial begin : stim
    int lat;
    int quiet;
    // Reset with up held: the held button must never register
    step(3);
    en = 1'b1;
    chk("rst_welcome", show_welcome, 1);
    chk("rst_valid", move_valid, 0);
    chk("rst_qc", queue_count, 0);
    chk("rst_gs", game_start, 0);
    reset = 0;
    step(3);
    chk("held_no_start", game_start, 0);
    chk("held_welcome", show_welcome, 1);
    btn = 4'b0000; step();
    btn = 4'b0001; step();
    chk("start_pulse", game_start, 1);
    chk("start_leave", show_welcome, 0);
    chk("start_qc", queue_count, 0);
    btn = 4'b0000; step();
    chk("start_once", game_start, 0);
    chk("start_qc2", queue_count, 0);

    // Single right move, committed on the next frame after done
    btn = 4'b1000; step();
    btn = 4'b0000; step();
    chk("right_qc", queue_count, 1);
    frame_start = 1; step(); frame_start = 0;
    chk("right_valid", move_valid, 1);
    chk("right_dir", move_dir, 3);
    move_ready = 1; step(); move_ready = 0;
    chk("right_pop", queue_count, 0);
    step(4);
    move_done = 1; step(); move_done = 0;
    chk("right_nocommit", grid_commit, 0);
    frame_start = 1; step(); frame_start = 0;
    chk("right_commit", grid_commit, 1);
    step();
    chk("right_commit_once", grid_commit, 0);

    // All four at once: queued up, down, left, right; extra left waits
    btn = 4'b1111; step();
    btn = 4'b0000; step(4);
    chk("all4_qc", queue_count, 4);
    btn = 4'b0100; step();
    btn = 4'b0000; step();
    chk("full_hold_qc", queue_count, 4);
    frame_start = 1; step(); frame_start = 0;
    chk("all4_dir_up", move_dir, 0);
    move_ready = 1; step(); move_ready = 0;
    chk("pop_qc", queue_count, 3);

    // No move_done: timeout DT cycles after acceptance, no commit
    lat = 0;
    while (!timeout && lat < 400) begin
      step();
      lat++;
      if (lat == 1) chk("refill_qc", queue_count, 4);
    end
    chk("timeout_latency", lat, DT);
    chk("timeout_nocommit", grid_commit, 0);
    step();
    chk("timeout_idle_valid", move_valid, 0);
    chk("timeout_once", timeout, 0);

    // Reset while in WAIT_FRAME with two queued moves
    do_move(1);
    frame_start = 1; step(); frame_start = 0;
    chk("mv_commit", grid_commit, 1);
    do_move(2);
    chk("wf_qc", queue_count, 2);
    reset = 1; step(); reset = 0;
    chk("mid_rst_welcome", show_welcome, 1);
    chk("mid_rst_qc", queue_count, 0);
    frame_start = 1; step(); frame_start = 0;
    chk("mid_rst_nocommit", grid_commit, 0);

    // Randomized traffic; periodic quiet windows without done force timeouts
    quiet = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 3) == 0) btn = 4'($urandom_range(0, 15));
      frame_start = ($urandom_range(0, 5) == 0);
      move_ready  = ($urandom_range(0, 2) != 0);
      if (i % 1500 == 700) quiet = 300;
      if (quiet > 0) begin
        quiet--;
        move_done = 1'b0;
      end else begin
        move_done = ($urandom_range(0, 4) == 0);
      end
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 0; frame_start = 0; move_ready = 0; move_done = 0; btn = 4'b0000;

`ifdef MOVE_SCHEDULER_REPEAT_EN
    // Hold left for 24 frames: one press plus repeats at 12, 18, 24
    reset = 1; step(2); reset = 0;
    btn = 4'b0000; step();
    btn = 4'b0001; step();
    btn = 4'b0000; step(2);
    btn = 4'b0100; step(3);
    for (int f = 0; f < 24; f++) begin
      frame_start = 1; step(); frame_start = 0; step(3);
    end
    step(2);
    chk("repeat_qc", queue_count, 4);
    btn = 4'b0000;
`endif

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
